// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The IF/ID register layout, the NOP/bubble encoding and the per-edge
// action code live here so the top level and ifid_reg agree on them.
package if_pkg;

    // Datapath width the IF/ID record is built with; the top-level XLEN
    // parameter is expected to match it.
    localparam int IF_XLEN = 32;

    // addi x0, x0, 0 -- the canonical RISC-V NOP.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Default program counter after reset.
    localparam logic [IF_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] pc4;
        logic [31:0]        instr;
        logic               valid;
    } ifid_t;

    // Bubble: a NOP marked invalid. pc4 stays pc+4 so the pair remains
    // self-consistent for anything downstream that reads it.
    localparam ifid_t IFID_BUBBLE = '{
        pc:    '0,
        pc4:   IF_XLEN'(4),
        instr: NOP_INSTR,
        valid: 1'b0
    };

    // What the stage does on a given edge (reset is handled in the flops).
    typedef enum logic [2:0] {
        ACT_FETCH    = 3'd0,  // capture instr_i, advance PC
        ACT_FLUSH    = 3'd1,  // bubble IF/ID, advance PC
        ACT_HALT     = 3'd2,  // out of range: bubble IF/ID, hold PC
        ACT_STALL    = 3'd3,  // hold PC and IF/ID
        ACT_REDIRECT = 3'd4   // bubble IF/ID, load aligned target PC
    } fetch_act_e;

    // Force a byte address onto a word boundary.
    function automatic logic [IF_XLEN-1:0] align_word(input logic [IF_XLEN-1:0] addr);
        return {addr[IF_XLEN-1:2], 2'b00};
    endfunction

endpackage : if_pkg

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with synchronous reset, bubble, load and hold.
// Priority inside the register: reset > bubble > load > hold.
module ifid_reg
    import if_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  logic  bubble_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t q;

    // IF/ID state: reset and bubble both load the bubble record.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            q <= IFID_BUBBLE;
        end else if (bubble_i) begin
            q <= IFID_BUBBLE;
        end else if (load_i) begin
            q <= d_i;
        end
    end

    assign q_o = q;

endmodule : ifid_reg

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage RISC-V pipeline.
// Owns the PC, drives the combinational instruction memory and captures
// the returned word into the IF/ID register. Handles load-use stall,
// EX redirect, flush and out-of-range halt.
// Optional build macro IF_PERF_CNT_EN adds fetch/bubble counters.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int              XLEN       = IF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              IMEM_WORDS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_pc4_o,
    output logic [31:0]     ifid_instr_o,
    output logic            ifid_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt_o,
    output logic [31:0]     bubble_cnt_o
`endif
);

    // One extra bit so the limit itself is representable even when the
    // memory would span the whole address space.
    localparam logic [XLEN:0] IMEM_LIMIT = (XLEN+1)'(IMEM_WORDS) << 2;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic            out_of_range;
    fetch_act_e      act;
    logic            ifid_load;
    logic            ifid_bubble;
    ifid_t           ifid_d;
    ifid_t           ifid_q;

    assign pc_plus4     = pc_q + XLEN'(4);
    assign out_of_range = ({1'b0, pc_q} >= IMEM_LIMIT);

    // Pick this edge's action in priority order, then derive next PC and
    // IF/ID controls from it.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case leaves a value unassigned (no latches).
        act         = ACT_FETCH;
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;

        if (redirect_i) begin
            act = ACT_REDIRECT;
        end else if (stall_i) begin
            act = ACT_STALL;
        end else if (out_of_range) begin
            act = ACT_HALT;
        end else if (flush_i) begin
            act = ACT_FLUSH;
        end

        case (act)
            ACT_REDIRECT: begin
                pc_d        = align_word(redirect_pc_i);
                ifid_bubble = 1'b1;
            end
            ACT_STALL: begin
                pc_d = pc_q;
            end
            ACT_HALT: begin
                ifid_bubble = 1'b1;
            end
            ACT_FLUSH: begin
                pc_d        = pc_plus4;
                ifid_bubble = 1'b1;
            end
            ACT_FETCH: begin
                pc_d      = pc_plus4;
                ifid_load = 1'b1;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Record presented to IF/ID on a normal fetch.
    always_comb begin
        ifid_d       = IFID_BUBBLE;
        ifid_d.pc    = pc_q;
        ifid_d.pc4   = pc_plus4;
        ifid_d.instr = instr_i;
        ifid_d.valid = 1'b1;
    end

    // Program counter register; reset wins over everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .d_i      (ifid_d),
        .q_o      (ifid_q)
    );

    assign pc_o         = pc_q;
    assign ifid_pc_o    = ifid_q.pc;
    assign ifid_pc4_o   = ifid_q.pc4;
    assign ifid_instr_o = ifid_q.instr;
    assign ifid_valid_o = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Count valid loads and every bubble-or-stall edge; both wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (ifid_load) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (ifid_bubble || (act == ACT_STALL)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule : if_fetch_stage

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage with a small combinational
// instruction-memory model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_i;
    logic [31:0] pc_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] imem [32];

    if_fetch_stage #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_i       (instr_i),
        .pc_o          (pc_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_valid_o  (ifid_valid_o)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o)
`endif
    );

    // Combinational memory; out-of-range reads return a poison word.
    assign instr_i = (pc_o < 32'd128) ? imem[pc_o[6:2]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit reached;

        for (int i = 0; i < 32; i++) begin
            imem[i] = 32'h1000_0000 + 32'(i);
        end
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h00A0_0113;

        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0;
        step();
        step();

        // Reset state
        check("rst_pc",    pc_o,         32'h0);
        check("rst_ifpc",  ifid_pc_o,    32'h0);
        check("rst_ifpc4", ifid_pc4_o,   32'h4);
        check("rst_instr", ifid_instr_o, NOP);
        check("rst_valid", 32'(ifid_valid_o), 32'h0);
`ifdef IF_PERF_CNT_EN
        check("rst_fcnt", fetch_cnt_o,  32'h0);
        check("rst_bcnt", bubble_cnt_o, 32'h0);
`endif

        // First fetches after reset release
        rst_i = 1'b0;
        step();
        check("e1_pc",    pc_o,         32'h4);
        check("e1_ifpc",  ifid_pc_o,    32'h0);
        check("e1_ifpc4", ifid_pc4_o,   32'h4);
        check("e1_instr", ifid_instr_o, 32'h0050_0093);
        check("e1_valid", 32'(ifid_valid_o), 32'h1);
        step();
        check("e2_pc",    pc_o,         32'h8);
        check("e2_ifpc",  ifid_pc_o,    32'h4);
        check("e2_ifpc4", ifid_pc4_o,   32'h8);
        check("e2_instr", ifid_instr_o, 32'h00A0_0113);

        // Two-cycle stall; flush during stall is ignored
        stall_i = 1'b1;
        step();
        check("st1_pc",    pc_o,         32'h8);
        check("st1_ifpc",  ifid_pc_o,    32'h4);
        check("st1_instr", ifid_instr_o, 32'h00A0_0113);
        check("st1_valid", 32'(ifid_valid_o), 32'h1);
        flush_i = 1'b1;
        step();
        check("st2_pc",    pc_o,         32'h8);
        check("st2_ifpc",  ifid_pc_o,    32'h4);
        check("st2_valid", 32'(ifid_valid_o), 32'h1);
        stall_i = 1'b0; flush_i = 1'b0;
        step();
        check("rel_pc",    pc_o,         32'hC);
        check("rel_ifpc",  ifid_pc_o,    32'h8);
        check("rel_instr", ifid_instr_o, 32'h1000_0002);

        // Flush: bubble, PC still advances
        flush_i = 1'b1;
        step();
        check("fl_pc",    pc_o,         32'h10);
        check("fl_valid", 32'(ifid_valid_o), 32'h0);
        check("fl_instr", ifid_instr_o, NOP);
        flush_i = 1'b0;

        // Redirect beats stall
        redirect_i = 1'b1; redirect_pc_i = 32'h20; stall_i = 1'b1;
        step();
        check("rd_pc",    pc_o,         32'h20);
        check("rd_valid", 32'(ifid_valid_o), 32'h0);
        check("rd_instr", ifid_instr_o, NOP);
        redirect_i = 1'b0; stall_i = 1'b0;
        step();
        check("rd2_ifpc",  ifid_pc_o,    32'h20);
        check("rd2_instr", ifid_instr_o, 32'h1000_0008);
        check("rd2_valid", 32'(ifid_valid_o), 32'h1);
        check("rd2_pc",    pc_o,         32'h24);

        // Misaligned redirect target
        redirect_i = 1'b1; redirect_pc_i = 32'h23;
        step();
        check("mis_pc", pc_o, 32'h20);
        redirect_i = 1'b0;

        // Run off the end of memory (bounded)
        reached = 1'b0;
        for (int n = 0; n < 40 && !reached; n++) begin
            step();
            if (pc_o == 32'h80) reached = 1'b1;
        end
        check("run_reached", 32'(reached), 32'h1);
        check("run_last_ifpc", ifid_pc_o, 32'h7C);
        for (int n = 0; n < 3; n++) begin
            step();
            check("oor_pc",    pc_o,         32'h80);
            check("oor_valid", 32'(ifid_valid_o), 32'h0);
            check("oor_instr", ifid_instr_o, NOP);
        end

        // Redirect back into range resumes fetch
        redirect_i = 1'b1; redirect_pc_i = 32'h0;
        step();
        check("back_pc",    pc_o, 32'h0);
        check("back_valid", 32'(ifid_valid_o), 32'h0);
        redirect_i = 1'b0;
        step();
        check("res_ifpc",  ifid_pc_o,    32'h0);
        check("res_instr", ifid_instr_o, 32'h0050_0093);
        check("res_valid", 32'(ifid_valid_o), 32'h1);
        check("res_pc",    pc_o,         32'h4);
`ifdef IF_PERF_CNT_EN
        // 2+1+24+1+1 fetches, 2 stall + flush + 2 redirect + 3 halt + 1 redirect
        check("cnt_fetch",  fetch_cnt_o,  32'd29);
        check("cnt_bubble", bubble_cnt_o, 32'd9);
`endif

        // Reset mid-redirect and mid-stall
        rst_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h40; stall_i = 1'b1;
        step();
        check("mr_pc",    pc_o,         32'h0);
        check("mr_valid", 32'(ifid_valid_o), 32'h0);
        check("mr_instr", ifid_instr_o, NOP);
`ifdef IF_PERF_CNT_EN
        check("mr_fcnt", fetch_cnt_o,  32'h0);
        check("mr_bcnt", bubble_cnt_o, 32'h0);
`endif
        rst_i = 1'b0; redirect_i = 1'b0; stall_i = 1'b0;
        step();
        check("post_ifpc",  ifid_pc_o,    32'h0);
        check("post_valid", 32'(ifid_valid_o), 32'h1);
        check("post_pc",    pc_o,         32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_fetch_stage
